// File: rtl/stopwatch_seq.sv
// Sequencer for an MM:SS.t stopwatch: 10 Hz prescaler, rippled digit enables,
// and the start/stop/lap/clear state machine driving five counter10 digits.
module stopwatch_seq #(
  parameter int CLK_DIV = 1_000_000,
  parameter int DIV_W   = 20
) (
  input  logic       clk,
  input  logic       res,
  input  logic       ena,
  input  logic       btn_ss,
  input  logic       btn_lr,
  input  logic [4:0] max_d,
  output logic [4:0] ena_d,
  output logic       cnt_res,
  output logic       disp_hold,
  output logic       running,
  output logic       ovf,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    LAP    = 3'd2,
    PAUSED = 3'd3,
    FULL   = 3'd4
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [DIV_W-1:0] presc_reg;
  logic             counting;
  logic             tick;
  logic             full_tick;
  logic             clear;
  logic [4:0]       carry;

  assign counting  = ena && ((state_reg == RUN) || (state_reg == LAP));
  assign tick      = counting && (presc_reg == DIV_W'(CLK_DIV - 1));
  assign full_tick = tick && (&max_d);

  // Digit i advances only when every lower digit is sitting at its maximum.
  assign carry[0] = 1'b1;
  generate
    for (genvar gi = 1; gi < 5; gi++) begin : g_carry
      assign carry[gi] = carry[gi-1] & max_d[gi-1];
    end
  endgenerate

  // Overflow outranks any button arriving in the same cycle.
  always_comb begin
    state_next = state_reg;
    if (ena) begin
      if (full_tick) begin
        state_next = FULL;
      end else begin
        case (state_reg)
          IDLE:    if (btn_ss) state_next = RUN;
          RUN:     if (btn_ss) state_next = PAUSED;
                   else if (btn_lr) state_next = LAP;
          LAP:     if (btn_ss) state_next = PAUSED;
                   else if (btn_lr) state_next = RUN;
          PAUSED:  if (btn_ss) state_next = RUN;
                   else if (btn_lr) state_next = IDLE;
          FULL:    if (!btn_ss && btn_lr) state_next = IDLE;
          default: state_next = IDLE;
        endcase
      end
    end
  end

  assign clear = (state_next == IDLE) && (state_reg != IDLE);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_reg <= IDLE;
      presc_reg <= '0;
      ena_d     <= '0;
      cnt_res   <= 1'b0;
      disp_hold <= 1'b0;
      running   <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state_reg <= state_next;
      disp_hold <= (state_next == LAP);
      running   <= (state_next == RUN) || (state_next == LAP);
      ovf       <= (state_next == FULL);
      cnt_res   <= !clear;
      ena_d     <= (tick && !full_tick) ? carry : 5'b00000;
      // PAUSED leaves the partial tenth in place so resume continues it.
      if (clear || tick) begin
        presc_reg <= '0;
      end else if (counting) begin
        presc_reg <= presc_reg + 1'b1;
      end
    end
  end

  assign state = state_reg;

endmodule

// File: tb/tb_stopwatch_seq.sv
// Directed bench for stopwatch_seq with a 4-cycle tenth; each task checks one scenario.
module tb_stopwatch_seq;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       ena = 1'b0;
  logic       btn_ss = 1'b0;
  logic       btn_lr = 1'b0;
  logic [4:0] max_d = 5'b00000;
  logic [4:0] ena_d;
  logic       cnt_res;
  logic       disp_hold;
  logic       running;
  logic       ovf;
  logic [2:0] state;

  int checks = 0;
  int fails  = 0;

  stopwatch_seq #(.CLK_DIV(4), .DIV_W(3)) dut (
    .clk(clk), .res(res), .ena(ena), .btn_ss(btn_ss), .btn_lr(btn_lr),
    .max_d(max_d), .ena_d(ena_d), .cnt_res(cnt_res), .disp_hold(disp_hold),
    .running(running), .ovf(ovf), .state(state)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, landing 1 ns after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    res = 1'b0; ena = 1'b0;
    cyc(2);
    checks++; if (state !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if ({ena_d, cnt_res, disp_hold, running, ovf} !== 9'b0) begin fails++;
      $display("FAIL reset_outputs: got %b expected 000000000", {ena_d, cnt_res, disp_hold, running, ovf}); end
    res = 1'b1;
    cyc(1);
    checks++; if (cnt_res !== 1'b1) begin fails++; $display("FAIL reset_cnt_res_release: got %b expected 1", cnt_res); end
    ena = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_first_tick();
    btn_ss = 1'b1; cyc(1); btn_ss = 1'b0;
    checks++; if (state !== 3'd1 || running !== 1'b1) begin fails++;
      $display("FAIL start_run: got state %0d running %b expected 1 1", state, running); end
    cyc(3);
    checks++; if (ena_d !== 5'b00000) begin fails++; $display("FAIL first_tick_early: got %b expected 00000", ena_d); end
    cyc(1);
    checks++; if (ena_d !== 5'b00001) begin fails++; $display("FAIL first_tick: got %b expected 00001", ena_d); end
    cyc(1);
    checks++; if (ena_d !== 5'b00000) begin fails++; $display("FAIL tick_pulse_width: got %b expected 00000", ena_d); end
    cyc(3);
    checks++; if (ena_d !== 5'b00001) begin fails++; $display("FAIL second_tick: got %b expected 00001", ena_d); end
    $display("test_first_tick done");
  endtask

  task automatic test_carry();
    logic [4:0] mx  [3] = '{5'b00011, 5'b00111, 5'b01111};
    logic [4:0] exp [3] = '{5'b00111, 5'b01111, 5'b11111};
    for (int i = 0; i < 3; i++) begin
      max_d = mx[i];
      cyc(4);
      checks++; if (ena_d !== exp[i]) begin fails++;
        $display("FAIL carry_%0d: got %b expected %b", i, ena_d, exp[i]); end
    end
    max_d = 5'b00000;
    $display("test_carry done");
  endtask

  task automatic test_lap();
    btn_lr = 1'b1; cyc(1); btn_lr = 1'b0;
    checks++; if (state !== 3'd2 || disp_hold !== 1'b1 || running !== 1'b1) begin fails++;
      $display("FAIL lap_enter: got state %0d hold %b running %b expected 2 1 1", state, disp_hold, running); end
    cyc(3);
    checks++; if (ena_d !== 5'b00001 || state !== 3'd2) begin fails++;
      $display("FAIL lap_counting: got ena_d %b state %0d expected 00001 2", ena_d, state); end
    btn_lr = 1'b1; cyc(1); btn_lr = 1'b0;
    checks++; if (state !== 3'd1 || disp_hold !== 1'b0) begin fails++;
      $display("FAIL lap_exit: got state %0d hold %b expected 1 0", state, disp_hold); end
    $display("test_lap done");
  endtask

  task automatic test_pause_resume();
    int pulses = 0;
    btn_ss = 1'b1; cyc(1); btn_ss = 1'b0;
    checks++; if (state !== 3'd3 || running !== 1'b0) begin fails++;
      $display("FAIL pause_enter: got state %0d running %b expected 3 0", state, running); end
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (ena_d !== 5'b00000) pulses++;
    end
    checks++; if (pulses !== 0) begin fails++; $display("FAIL pause_no_enables: got %0d pulses expected 0", pulses); end
    btn_ss = 1'b1; cyc(1); btn_ss = 1'b0;
    checks++; if (state !== 3'd1) begin fails++; $display("FAIL resume: got state %0d expected 1", state); end
    cyc(1);
    checks++; if (ena_d !== 5'b00000) begin fails++; $display("FAIL resume_partial_early: got %b expected 00000", ena_d); end
    cyc(1);
    checks++; if (ena_d !== 5'b00001) begin fails++; $display("FAIL resume_partial_tick: got %b expected 00001", ena_d); end
    $display("test_pause_resume done");
  endtask

  task automatic test_overflow();
    max_d = 5'b11111;
    cyc(3);
    checks++; if (state !== 3'd1) begin fails++; $display("FAIL pre_overflow_state: got %0d expected 1", state); end
    cyc(1);
    checks++; if (ena_d !== 5'b00000 || state !== 3'd4 || ovf !== 1'b1 || running !== 1'b0) begin fails++;
      $display("FAIL overflow: got ena_d %b state %0d ovf %b running %b expected 00000 4 1 0", ena_d, state, ovf, running); end
    btn_ss = 1'b1; cyc(1); btn_ss = 1'b0;
    checks++; if (state !== 3'd4) begin fails++; $display("FAIL full_ignores_ss: got %0d expected 4", state); end
    btn_lr = 1'b1; cyc(1); btn_lr = 1'b0;
    checks++; if (state !== 3'd0 || cnt_res !== 1'b0 || ovf !== 1'b0) begin fails++;
      $display("FAIL full_clear: got state %0d cnt_res %b ovf %b expected 0 0 0", state, cnt_res, ovf); end
    cyc(1);
    checks++; if (cnt_res !== 1'b1) begin fails++; $display("FAIL clear_one_cycle: got %b expected 1", cnt_res); end
    max_d = 5'b00000;
    $display("test_overflow done");
  endtask

  task automatic test_both_buttons();
    btn_ss = 1'b1; cyc(1); btn_ss = 1'b0;
    btn_ss = 1'b1; btn_lr = 1'b1; cyc(1); btn_ss = 1'b0; btn_lr = 1'b0;
    checks++; if (state !== 3'd3 || disp_hold !== 1'b0) begin fails++;
      $display("FAIL both_buttons: got state %0d hold %b expected 3 0", state, disp_hold); end
    btn_lr = 1'b1; cyc(1); btn_lr = 1'b0;
    checks++; if (state !== 3'd0 || cnt_res !== 1'b0) begin fails++;
      $display("FAIL paused_clear: got state %0d cnt_res %b expected 0 0", state, cnt_res); end
    $display("test_both_buttons done");
  endtask

  task automatic test_ena_low();
    int pulses = 0;
    cyc(1);
    btn_ss = 1'b1; cyc(1); btn_ss = 1'b0;
    cyc(3);
    ena = 1'b0;
    btn_lr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (ena_d !== 5'b00000) pulses++;
    end
    btn_lr = 1'b0;
    checks++; if (pulses !== 0 || state !== 3'd1) begin fails++;
      $display("FAIL ena_low_freeze: got %0d pulses state %0d expected 0 1", pulses, state); end
    ena = 1'b1;
    cyc(1);
    checks++; if (ena_d !== 5'b00001) begin fails++; $display("FAIL ena_tick_kept: got %b expected 00001", ena_d); end
    $display("test_ena_low done");
  endtask

  task automatic test_async_reset();
    cyc(1);
    res = 1'b0;
    #2;
    checks++; if (state !== 3'd0 || running !== 1'b0 || cnt_res !== 1'b0 || ena_d !== 5'b00000) begin fails++;
      $display("FAIL async_reset: got state %0d running %b cnt_res %b ena_d %b expected 0 0 0 00000", state, running, cnt_res, ena_d); end
    cyc(1);
    res = 1'b1;
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_carry();
    test_lap();
    test_pause_resume();
    test_overflow();
    test_both_buttons();
    test_ena_low();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
